// File: rtl/arduino_uart_tx_buffer.sv
// Buffered 9N1 UART transmitter: a synchronous FIFO of core words drained
// LSB-first onto a single idle-high serial line towards the Arduino.
module arduino_uart_tx_buffer #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DATA_BITS    = 9,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                          clk_50,
  input  logic                          reset,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          uart_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e               state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [IW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic [PW-1:0]        wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]        count_q, count_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

  logic push, pop, baud_end;

  // Full check uses the registered count only, so a same-edge pop never frees a slot.
  assign tx_ready   = (count_q != CW'(FIFO_DEPTH));
  assign push       = tx_valid && tx_ready;
  assign baud_end   = (baud_q == BW'(CLKS_PER_BIT - 1));
  assign uart_tx    = tx_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_q];
          tx_d    = 1'b0;
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          tx_d    = shift_q[0];
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == IW'(DATA_BITS - 1)) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_d   = bit_q + IW'(1);
            shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          // Chain straight into the next start bit when more words are waiting.
          if (count_q != '0) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_q];
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    wr_d    = push ? wr_q + PW'(1) : wr_q;
    rd_d    = pop  ? rd_q + PW'(1) : rd_q;
    count_d = count_q + CW'(push) - CW'(pop);
    busy_d  = (state_d != IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk_50) begin
    if (push) mem_q[wr_q] <= tx_data;
  end

endmodule

// File: tb/tb_arduino_uart_tx_buffer.sv
// Self-checking bench for arduino_uart_tx_buffer at 4 clocks per bit.
module tb_arduino_uart_tx_buffer;

  logic       clk_50;
  logic       reset;
  logic [8:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       uart_tx;
  logic       busy;
  logic [3:0] fifo_count;

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b1;
  logic [8:0] rx_q [$];

  typedef struct {
    logic [8:0]  data;
    logic [10:0] frame;
  } vec_t;
  vec_t vec [5];

  arduino_uart_tx_buffer #(
    .CLKS_PER_BIT(4),
    .DATA_BITS(9),
    .FIFO_DEPTH(8)
  ) dut (
    .clk_50(clk_50),
    .reset(reset),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .uart_tx(uart_tx),
    .busy(busy),
    .fifo_count(fifo_count)
  );

  initial clk_50 = 1'b0;
  always #5 clk_50 = ~clk_50;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_50);
      #1;
    end
  endtask

  // Producer: hold the word until the buffer has room, then present it for one edge.
  task automatic push(input logic [8:0] d);
    int n = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    while (!tx_ready && n < 200) begin
      tick();
      n++;
    end
    chk("push_ready", tx_ready, 1);
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int c = 0;
    while (rx_q.size() < n && c < budget) begin
      tick();
      c++;
    end
    chk("rx_count", rx_q.size(), n);
  endtask

  // Independent UART receiver sampling mid-bit.
  initial begin : monitor
    logic [8:0] w;
    logic       stop;
    forever begin
      tick();
      if (reset && uart_tx == 1'b0) begin
        tick(2);
        for (int i = 0; i < 9; i++) begin
          tick(4);
          w[i] = uart_tx;
        end
        tick(4);
        stop = uart_tx;
        if (mon_en) begin
          chk("mon_stop_bit", stop, 1);
          rx_q.push_back(w);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [10:0] f;
    logic [10:0] f0, f1;
    int lows;

    // Frame bits, LSB = start bit, MSB = stop bit.
    vec[0] = '{data: 9'h1A5, frame: 11'h74A};
    vec[1] = '{data: 9'h000, frame: 11'h400};
    vec[2] = '{data: 9'h1FF, frame: 11'h7FE};
    vec[3] = '{data: 9'h0AA, frame: 11'h554};
    vec[4] = '{data: 9'h155, frame: 11'h6AA};

    reset    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    tick(5);
    reset = 1'b1;
    tick();
    chk("rst_uart_tx", uart_tx, 1);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_busy", busy, 0);

    // Single frames into an idle block.
    for (int v = 0; v < 5; v++) begin
      rx_q.delete();
      tx_data  = vec[v].data;
      tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      chk("single_count", fifo_count, 1);
      chk("single_line_pre", uart_tx, 1);
      for (int k = 0; k < 44; k++) begin
        tick();
        f = vec[v].frame >> (k / 4);
        chk("single_line", uart_tx, f[0]);
      end
      chk("single_busy_last", busy, 1);
      tick();
      chk("single_busy_end", busy, 0);
      chk("single_rx_n", rx_q.size(), 1);
      if (rx_q.size() > 0) chk("single_rx_word", rx_q[0], vec[v].data);
      tick(3);
    end

    // Back-to-back frames with no idle gap.
    rx_q.delete();
    f0 = 11'h402;
    f1 = 11'h7FE;
    tx_data  = 9'h001;
    tx_valid = 1'b1;
    tick();
    tx_data = 9'h1FF;
    tick();
    tx_valid = 1'b0;
    for (int k = 0; k < 88; k++) begin
      if (k > 0) tick();
      f = ((k < 44) ? f0 : f1) >> ((k % 44) / 4);
      chk("b2b_line", uart_tx, f[0]);
    end
    tick();
    chk("b2b_busy_end", busy, 0);
    chk("b2b_rx_n", rx_q.size(), 2);
    if (rx_q.size() == 2) begin
      chk("b2b_rx0", rx_q[0], 9'h001);
      chk("b2b_rx1", rx_q[1], 9'h1FF);
    end
    tick(3);

    // Fill the FIFO while the first frame is on the line.
    rx_q.delete();
    for (int i = 0; i < 9; i++) push(9'h100 + 9'(i));
    chk("full_count", fifo_count, 8);
    chk("full_ready", tx_ready, 0);
    tx_data  = 9'h109;
    tx_valid = 1'b1;
    tick(20);
    chk("full_refused_count", fifo_count, 8);
    push(9'h109);
    wait_rx(10, 600);
    for (int i = 0; i < 10; i++)
      if (i < rx_q.size()) chk("full_order", rx_q[i], 9'h100 + 9'(i));
    tick(5);
    chk("full_idle_busy", busy, 0);

    // Long stream exercising pointer wrap-around.
    rx_q.delete();
    for (int i = 0; i < 20; i++) push(9'(i));
    wait_rx(20, 1000);
    for (int i = 0; i < 20; i++)
      if (i < rx_q.size()) chk("wrap_order", rx_q[i], 9'(i));
    tick(5);

    // Asynchronous reset in the middle of data bit 4 of 9'h0AA.
    mon_en = 1'b0;
    push(9'h0AA);
    push(9'h101);
    push(9'h102);
    push(9'h103);
    chk("mid_count", fifo_count, 3);
    tick(19);
    chk("mid_bit4_low", uart_tx, 0);
    reset = 1'b0;
    #1;
    chk("mid_rst_line", uart_tx, 1);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", tx_ready, 1);
    tick(3);
    reset = 1'b1;
    lows = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (uart_tx !== 1'b1) lows++;
    end
    chk("post_rst_line_low_cycles", lows, 0);
    chk("post_rst_count", fifo_count, 0);
    chk("post_rst_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arduino_uart_tx_buffer.md
Name: arduino_uart_tx_buffer

Overview:
- Outbound counterpart of the Arduino receive path: carries 9-bit messages from the FPGA core to the Arduino.
- Buffers core-side words in a synchronous FIFO and serialises each word onto a single UART line as a 9N1 frame.
- Single clock domain (clk_50); the Arduino samples the line asynchronously, so no clock-domain-crossing FIFO is needed.
- Sits between core message producers and the Arduino RX pin.

Parameters:
- CLKS_PER_BIT, 434, clk_50 cycles per UART bit (50 MHz / 115200 baud).
- DATA_BITS, 9, payload bits per frame; matches the 9-bit Arduino message width.
- FIFO_DEPTH, 8, word capacity of the buffer; must be a power of two, ≥2.

Ports:
- clk_50  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- tx_data  input  DATA_BITS  message to send.
- tx_valid  input  1  tx_data is valid this cycle.
- tx_ready  output  1  buffer can accept a word (FIFO not full).
- uart_tx  output  1  serial line to the Arduino; idles high.
- busy  output  1  high while a frame is on the line or the FIFO is non-empty.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  number of words currently buffered.

Behaviour:
- Reset (reset=0, asynchronous):
  - uart_tx=1, busy=0, fifo_count=0, tx_ready=1.
  - FSM goes to IDLE; FIFO pointers, bit counter and baud counter cleared.
  - Reset mid-frame truncates the frame immediately (line returns high) and discards all buffered words.
- Write handshake:
  - A word is accepted on a rising edge where tx_valid=1 and tx_ready=1.
  - tx_ready = (fifo_count != FIFO_DEPTH), combinational from registered count.
  - tx_ready does NOT account for a same-cycle pop: when full, the push is refused even if a pop occurs on that edge.
  - A refused word is not stored; the producer holds tx_valid/tx_data until accepted.
  - An all-zero tx_data is a legal word and is transmitted.
- FIFO:
  - Circular buffer with wrap-around pointers.
  - A simultaneous push and pop leaves fifo_count unchanged; data ordering is preserved.
- FSM states: IDLE, START, DATA, STOP. All outputs are registered.
  - IDLE: uart_tx=1. On an edge with fifo_count>0: pop the head word into the shift register, uart_tx←0, baud counter←0, go to START.
  - START: hold for CLKS_PER_BIT cycles, then uart_tx←shift[0], bit index←0, go to DATA.
  - DATA: each bit held CLKS_PER_BIT cycles, LSB first. After DATA_BITS bits, uart_tx←1, go to STOP.
  - STOP: hold 1 for CLKS_PER_BIT cycles. At the end, if fifo_count>0, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Latency: a word pushed into an empty, idle block at edge E drives uart_tx low from edge E+1. Frame length is (DATA_BITS+2)×CLKS_PER_BIT cycles.
- busy = (state != IDLE) || (fifo_count != 0).
- The baud counter counts 0..CLKS_PER_BIT-1 and wraps; no fractional-baud correction.

Test Plan:
- Reset checks: reset=0 held 5 cycles, then released -> uart_tx=1, tx_ready=1, fifo_count=0, busy=0.
- Single frame, CLKS_PER_BIT=4: push 9'h1A5 into an idle block -> from next edge the line reads 0 (4 cycles), then 1,0,1,0,0,1,0,1,1 (4 cycles each), then 1 (4 cycles). Total 44 cycles; busy drops at the end.
- Back-to-back: push 9'h001 then 9'h1FF on consecutive cycles -> second start bit begins the cycle immediately after the first stop bit ends; 88 contiguous framed cycles, no idle gap.
- Full FIFO, FIFO_DEPTH=8: push 9 words while the first frame is in flight -> first word popped, then 8 accepted, fifo_count=8, tx_ready=0. A 10th tx_valid is not accepted until the next pop; all transmitted words appear in push order.
- Pointer wrap: stream 20 words 9'h000..9'h013 with tx_valid held -> all 20 frames decoded in order by the bench UART monitor, none lost.
- Reset mid-frame: assert reset during the DATA bit 4 of 9'h0AA with 3 words queued -> uart_tx=1 immediately (same cycle, asynchronous), fifo_count=0. After release, no further frames are sent.
